// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings (also used by uart_tx) and receiver states.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, reset to RST_VAL.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 3-sample majority vote per bit, parity/stop checks,
// one-cycle rx_valid strobe per completed frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY     = PARITY_NONE,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_wire,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int HALF = OVERSAMPLE / 2;
  localparam int TW   = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam logic ODD = (PARITY == PARITY_ODD);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx: STOP_BITS must be 1 or 2");
  end

  logic rxs;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_wire),
    .q     (rxs)
  );

  rx_state_e            state, state_nxt;
  logic [TW-1:0]        tcnt, tcnt_nxt;
  logic [BW-1:0]        bcnt, bcnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt, data_nxt;
  logic                 s0, s0_nxt, s1, s1_nxt;
  logic                 perr_acc, perr_acc_nxt, ferr_acc, ferr_acc_nxt;
  logic                 perr_nxt, ferr_nxt, valid_nxt, ferr_now;
  logic                 decide, vote;

  // Third sample is the live synchronized value on the decision tick.
  assign decide  = baud_tick && (tcnt == TW'(HALF + 1));
  assign vote    = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign rx_busy = (state != RX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RX_IDLE;
      tcnt          <= '0;
      bcnt          <= '0;
      shreg         <= '0;
      s0            <= 1'b1;
      s1            <= 1'b1;
      perr_acc      <= 1'b0;
      ferr_acc      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_valid      <= 1'b0;
    end else begin
      state         <= state_nxt;
      tcnt          <= tcnt_nxt;
      bcnt          <= bcnt_nxt;
      shreg         <= shreg_nxt;
      s0            <= s0_nxt;
      s1            <= s1_nxt;
      perr_acc      <= perr_acc_nxt;
      ferr_acc      <= ferr_acc_nxt;
      rx_data       <= data_nxt;
      rx_parity_err <= perr_nxt;
      rx_frame_err  <= ferr_nxt;
      rx_valid      <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tcnt_nxt     = tcnt;
    bcnt_nxt     = bcnt;
    shreg_nxt    = shreg;
    s0_nxt       = s0;
    s1_nxt       = s1;
    perr_acc_nxt = perr_acc;
    ferr_acc_nxt = ferr_acc;
    data_nxt     = rx_data;
    perr_nxt     = rx_parity_err;
    ferr_nxt     = rx_frame_err;
    valid_nxt    = 1'b0;
    ferr_now     = ferr_acc | ~vote;

    if (baud_tick) begin
      tcnt_nxt = (tcnt == TW'(OVERSAMPLE - 1)) ? '0 : tcnt + 1'b1;
      if (tcnt == TW'(HALF - 1)) s0_nxt = rxs;
      if (tcnt == TW'(HALF))     s1_nxt = rxs;

      unique case (state)
        RX_IDLE: begin
          // The detecting tick is tick 0 of the start bit.
          tcnt_nxt = rxs ? '0 : TW'(1);
          if (!rxs) begin
            state_nxt    = RX_START;
            perr_acc_nxt = 1'b0;
            ferr_acc_nxt = 1'b0;
          end
        end
        RX_START: if (decide) begin
          state_nxt = vote ? RX_IDLE : RX_DATA;
          bcnt_nxt  = '0;
        end
        RX_DATA: if (decide) begin
          shreg_nxt = {vote, shreg[DATA_BITS-1:1]};
          if (bcnt == BW'(DATA_BITS - 1)) begin
            bcnt_nxt  = '0;
            state_nxt = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
          end else begin
            bcnt_nxt = bcnt + 1'b1;
          end
        end
        RX_PARITY: if (decide) begin
          perr_acc_nxt = ((^shreg) ^ vote) != ODD;
          state_nxt    = RX_STOP;
        end
        RX_STOP: if (decide) begin
          ferr_acc_nxt = ferr_now;
          if (bcnt == BW'(STOP_BITS - 1)) begin
            data_nxt  = shreg;
            perr_nxt  = perr_acc;
            ferr_nxt  = ferr_now;
            valid_nxt = 1'b1;
            bcnt_nxt  = '0;
            // Returning at mid-stop lets a back-to-back start edge be caught.
            state_nxt = ferr_now ? RX_WAIT_IDLE : RX_IDLE;
          end else begin
            bcnt_nxt = bcnt + 1'b1;
          end
        end
        RX_WAIT_IDLE: if (rxs) state_nxt = RX_IDLE;
        default: state_nxt = RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: three instances (default, even parity, 7N2) on one clock.
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [1:0] pc = 2'd0;
  logic [2:0] rxw = 3'b111;

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [2:0] vld, pe, fe, bsy;
  logic [8:0] dat [3];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // One baud tick every 4 clk, so one bit (8 ticks) lasts 32 clk.
  always @(posedge clk) begin
    pc        <= pc + 2'd1;
    baud_tick <= (pc == 2'd3);
  end

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_def (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_wire(rxw[0]),
    .rx_data(d0), .rx_valid(vld[0]), .rx_parity_err(pe[0]), .rx_frame_err(fe[0]),
    .rx_busy(bsy[0]));

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY(PARITY_EVEN), .STOP_BITS(1)) u_par (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_wire(rxw[1]),
    .rx_data(d1), .rx_valid(vld[1]), .rx_parity_err(pe[1]), .rx_frame_err(fe[1]),
    .rx_busy(bsy[1]));

  uart_rx #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY(PARITY_NONE), .STOP_BITS(2)) u_b7 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_wire(rxw[2]),
    .rx_data(d2), .rx_valid(vld[2]), .rx_parity_err(pe[2]), .rx_frame_err(fe[2]),
    .rx_busy(bsy[2]));

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {1'b0, d1};
  assign dat[2] = {2'b00, d2};

  int         vcnt [3] = '{0, 0, 0};
  int         ecnt [3] = '{0, 0, 0};
  logic [8:0] cap  [3];
  logic [8:0] capp [3];
  logic       cpe  [3];
  logic       cfe  [3];
  int         run = 0;
  int         maxrun = 0;

  // Capture each strobe; consecutive-high length of u_def's rx_valid is tracked too.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i]) begin
        vcnt[i]++;
        capp[i] = cap[i];
        cap[i]  = dat[i];
        cpe[i]  = pe[i];
        cfe[i]  = fe[i];
        if (pe[i] || fe[i]) ecnt[i]++;
      end
    end
    run = vld[0] ? run + 1 : 0;
    if (run > maxrun) maxrun = run;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // Frame driver; pbit < 0 means no parity bit, gb >= 0 puts a 4-clk inverted pulse mid data bit gb.
  task automatic send(input int d, input logic [8:0] data, input int nb, input int pbit,
                      input int ns, input int gb);
    rxw[d] = 1'b0;
    wait_clk(32);
    for (int i = 0; i < nb; i++) begin
      rxw[d] = data[i];
      if (i == gb) begin
        wait_clk(16);
        rxw[d] = ~data[i];
        wait_clk(4);
        rxw[d] = data[i];
        wait_clk(12);
      end else begin
        wait_clk(32);
      end
    end
    if (pbit >= 0) begin
      rxw[d] = pbit[0];
      wait_clk(32);
    end
    for (int i = 0; i < ns; i++) begin
      rxw[d] = 1'b1;
      wait_clk(32);
    end
  endtask

  int base, ebase;

  initial begin
    wait_clk(3);
    chk("rst_data",  32'(d0), 32'h0);
    chk("rst_valid", 32'(vld[0]), 32'h0);
    chk("rst_perr",  32'(pe[0]), 32'h0);
    chk("rst_ferr",  32'(fe[0]), 32'h0);
    chk("rst_busy",  32'(bsy), 32'h0);
    rst_n = 1'b1;
    wait_clk(10);

    // 8N1 0x55
    base = vcnt[0]; ebase = ecnt[0];
    send(0, 9'h055, 8, -1, 1, -1);
    wait_clk(8);
    chk("b55_cnt",  32'(vcnt[0] - base), 32'd1);
    chk("b55_data", 32'(cap[0]), 32'h55);
    chk("b55_errs", 32'(ecnt[0] - ebase), 32'd0);
    chk("b55_busy", 32'(bsy[0]), 32'h0);

    // Even parity, 0xA3 has four ones: parity bit 1 is wrong, 0 is right
    base = vcnt[1];
    send(1, 9'h0A3, 8, 1, 1, -1);
    wait_clk(8);
    chk("par_bad_cnt",  32'(vcnt[1] - base), 32'd1);
    chk("par_bad_data", 32'(cap[1]), 32'hA3);
    chk("par_bad_perr", 32'(cpe[1]), 32'h1);
    chk("par_bad_ferr", 32'(cfe[1]), 32'h0);
    send(1, 9'h0A3, 8, 0, 1, -1);
    wait_clk(8);
    chk("par_ok_cnt",  32'(vcnt[1] - base), 32'd2);
    chk("par_ok_data", 32'(cap[1]), 32'hA3);
    chk("par_ok_perr", 32'(cpe[1]), 32'h0);

    // Break: line low for two full frames
    base = vcnt[0];
    rxw[0] = 1'b0;
    wait_clk(640);
    chk("brk_cnt",  32'(vcnt[0] - base), 32'd1);
    chk("brk_data", 32'(cap[0]), 32'h00);
    chk("brk_ferr", 32'(cfe[0]), 32'h1);
    chk("brk_perr", 32'(cpe[0]), 32'h0);
    chk("brk_busy", 32'(bsy[0]), 32'h1);
    rxw[0] = 1'b1;
    wait_clk(40);
    chk("brk_busy_end", 32'(bsy[0]), 32'h0);
    chk("brk_no_more",  32'(vcnt[0] - base), 32'd1);

    // 2-tick low glitch from idle is a false start
    base = vcnt[0];
    rxw[0] = 1'b0;
    wait_clk(8);
    rxw[0] = 1'b1;
    wait_clk(64);
    chk("glt_cnt",  32'(vcnt[0] - base), 32'd0);
    chk("glt_busy", 32'(bsy[0]), 32'h0);

    // 0x0F with a one-tick high pulse in data bit 5 (a zero)
    ebase = ecnt[0];
    send(0, 9'h00F, 8, -1, 1, 5);
    wait_clk(8);
    chk("hgl_cnt",  32'(vcnt[0] - base), 32'd1);
    chk("hgl_data", 32'(cap[0]), 32'h0F);
    chk("hgl_errs", 32'(ecnt[0] - ebase), 32'd0);

    // Back-to-back frames, no idle gap
    base = vcnt[0]; ebase = ecnt[0];
    send(0, 9'h000, 8, -1, 1, -1);
    send(0, 9'h0FF, 8, -1, 1, -1);
    wait_clk(8);
    chk("b2b_cnt",   32'(vcnt[0] - base), 32'd2);
    chk("b2b_first", 32'(capp[0]), 32'h00);
    chk("b2b_last",  32'(cap[0]), 32'hFF);
    chk("b2b_errs",  32'(ecnt[0] - ebase), 32'd0);

    base = vcnt[2]; ebase = ecnt[2];
    send(2, 9'h000, 7, -1, 2, -1);
    send(2, 9'h07E, 7, -1, 2, -1);
    wait_clk(8);
    chk("b7_cnt",   32'(vcnt[2] - base), 32'd2);
    chk("b7_first", 32'(capp[2]), 32'h00);
    chk("b7_last",  32'(cap[2]), 32'h7E);
    chk("b7_errs",  32'(ecnt[2] - ebase), 32'd0);

    // Reset mid-frame: 0xC3 is LSB-first 1,1,0,0 ... ; stop half way through bit 4
    base = vcnt[0];
    rxw[0] = 1'b0;
    wait_clk(32);
    rxw[0] = 1'b1; wait_clk(32);
    rxw[0] = 1'b1; wait_clk(32);
    rxw[0] = 1'b0; wait_clk(32);
    rxw[0] = 1'b0; wait_clk(16);
    chk("mid_busy_pre", 32'(bsy[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_data",  32'(d0), 32'h0);
    chk("mid_busy",  32'(bsy[0]), 32'h0);
    chk("mid_valid", 32'(vld[0]), 32'h0);
    chk("mid_ferr",  32'(fe[0]), 32'h0);
    rxw[0] = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(320);
    chk("mid_no_valid", 32'(vcnt[0] - base), 32'd0);
    send(0, 9'h0C3, 8, -1, 1, -1);
    wait_clk(8);
    chk("c3_cnt",  32'(vcnt[0] - base), 32'd1);
    chk("c3_data", 32'(cap[0]), 32'hC3);
    chk("c3_ferr", 32'(cfe[0]), 32'h0);

    chk("valid_width", 32'(maxrun), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Parametrised, oversampling UART receiver that pairs with `uart_tx` and is driven by the `baud_generator` tick. It recovers frames from the asynchronous `rx_wire`, checks start, parity and stop bits, and presents each received word with a one-cycle `rx_valid` strobe and per-frame error flags. It replaces ad-hoc shift-register sampling in benches and is the receive half of the UART in the design.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `OVERSAMPLE`, 8: `baud_tick` pulses per bit period; even, at least 4.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `baud_tick`, in, 1: single-`clk`-cycle pulse at OVERSAMPLE × baud rate.
- `rx_wire`, in, 1: asynchronous serial input; idle high.
- `rx_data`, out, DATA_BITS: last received word, LSB first on the wire. Held until the next frame completes.
- `rx_valid`, out, 1: one-`clk` pulse when `rx_data` and the error flags update.
- `rx_parity_err`, out, 1: parity mismatch on the last frame. Always 0 when `PARITY` = 0.
- `rx_frame_err`, out, 1: a stop bit was sampled low on the last frame.
- `rx_busy`, out, 1: high from start detection until return to IDLE.

## Operation
- `rx_wire` passes through a 2-flop synchronizer; both flops reset to 1. All downstream logic uses the synchronized signal `rxs`.
- All counters advance only on `clk` cycles with `baud_tick` = 1.
- Reset values:
  - `rx_data` = 0; `rx_valid`, `rx_parity_err`, `rx_frame_err` and `rx_busy` = 0.
  - State = IDLE; tick and bit counters = 0.
- Tick 0 is the first tick on which `rxs` = 0 in IDLE.
- Bit k (start bit = 0, data bits 1..DATA_BITS, then parity, then stops) is decided by majority vote of `rxs`.
  - Samples are taken at ticks k·OVERSAMPLE + OVERSAMPLE/2 − 1, +0 and +1.
  - The decision is made on the +1 tick.
- States:
  - **IDLE**: on tick with `rxs` = 0, go to START, set `rx_busy`.
  - **START**: if the vote is 1 (false start/glitch), go to IDLE and clear `rx_busy`. No `rx_valid`. Otherwise go to DATA.
  - **DATA**: shift the voted bit into the MSB, shifting right, so the first bit lands in the LSB after DATA_BITS shifts. After the last data bit, go to PARITY if `PARITY` ≠ 0, else STOP.
  - **PARITY**: compute the error as XOR of data bits and the voted parity bit, compared against 0 (even) or 1 (odd). Go to STOP.
  - **STOP**: vote each stop bit; any 0 sets the frame error.
    - On the decision tick of the last stop bit, register `rx_data` and both flags. Pulse `rx_valid` on the next `clk`.
    - If no frame error, go to IDLE and clear `rx_busy`. Start detection re-arms from mid-stop, so back-to-back frames are received.
    - If frame error, go to WAIT_IDLE.
  - **WAIT_IDLE** (break or line stuck low): remain while `rxs` = 0. On the first tick with `rxs` = 1, go to IDLE and clear `rx_busy`. No further `rx_valid` is produced.
- No backpressure: a new frame overwrites `rx_data`. The consumer must capture on `rx_valid`.
- Reset asserted mid-frame aborts immediately to the reset values; no `rx_valid` is produced.

## Timing
- Synchronizer latency is 2 `clk` from `rx_wire` to `rxs`.
- `rx_valid` is high exactly one `clk`: the cycle after the final stop-bit decision tick.
- Frame length in ticks = OVERSAMPLE × (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS).
- From tick 0, `rx_valid` occurs OVERSAMPLE·(frame bits − 1) + OVERSAMPLE/2 + 1 ticks later, plus 1 `clk`.
- The tick counter wraps at OVERSAMPLE − 1. The bit counter is sized `$clog2(DATA_BITS+1)`.

## Structure
- Package `uart_pkg` holds:
  - parity encodings `PARITY_NONE`, `PARITY_EVEN`, `PARITY_ODD`;
  - the receiver state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE).
- `uart_tx` is to share the parity encodings.
- Sub-module `uart_sync2`: 2-flop synchronizer with a reset-value parameter, instantiated here with reset value 1.
- Elaboration checks enforce the parameter ranges and an even `OVERSAMPLE`.

## Test plan
- Defaults, `uart_tx` sends 0x55 → one `rx_valid`, `rx_data` = 0x55, both errors 0, `rx_busy` low after the pulse.
- `PARITY` = 1, drive 0xA3 with parity bit 1 (wrong) → `rx_data` = 0xA3, `rx_parity_err` = 1, `rx_frame_err` = 0. Repeat with parity bit 0 → `rx_parity_err` = 0.
- Hold line low for 2 full frames (break) → one `rx_valid` with `rx_data` = 0x00 and `rx_frame_err` = 1. `rx_busy` stays high until the line goes high, then no further `rx_valid`.
- Low glitch of 2 ticks from idle → no `rx_valid`, `rx_busy` returns to 0. A 1-tick high glitch at a data-bit mid-sample is outvoted, and 0x0F is received intact.
- Back-to-back 0x00 then 0xFF, 1 stop, no idle gap → two `rx_valid` pulses with 0x00 and 0xFF, no errors. Repeat with `DATA_BITS` = 7, `STOP_BITS` = 2 and 0x7E.
- Assert `rst_n` during bit 4 of a frame → all outputs 0 at once, no `rx_valid`. The next clean frame 0xC3 is received correctly.
